// File: rtl/if_stage.sv
// if_stage: instruction-fetch stage of the pipelined RV32I core.
//
// Holds the program counter, drives the instruction ROM address and registers the fetched
// instruction into the IF/ID pipeline register. A branch/jump resolved in EX (npc_op_i) redirects
// fetch to npc_bj_i, squashes the wrong-path instruction in IF/ID and kills the ID/EX slot.
//
// Ports:
//   clk_i          clock, all state updates on the rising edge
//   rst_i          synchronous active-high reset
//   stall_if_i     hold PC and IF/ID this cycle (hazard unit)
//   npc_op_i       redirect request from EX, overrides stall_if_i
//   npc_bj_i       redirect target
//   irom_inst_i    instruction read combinationally from the ROM at inst_addr_o
//   inst_addr_o    current PC
//   id_pc_o        PC of the instruction held in IF/ID
//   id_pc4_o       id_pc_o + 4
//   id_inst_o      instruction held in IF/ID
//   id_valid_o     IF/ID holds a real instruction (not a bubble)
//   flush_idex_o   ID/EX must load a bubble (combinational)
//   misalign_err_o sticky: a redirect target had non-zero low bits
//   redirect_cnt_o number of accepted redirects, wraps modulo 2^32
module if_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        stall_if_i,
   input  logic        npc_op_i,
   input  logic [31:0] npc_bj_i,
   input  logic [31:0] irom_inst_i,
   output logic [31:0] inst_addr_o,
   output logic [31:0] id_pc_o,
   output logic [31:0] id_pc4_o,
   output logic [31:0] id_inst_o,
   output logic        id_valid_o,
   output logic        flush_idex_o,
   output logic        misalign_err_o,
   output logic [31:0] redirect_cnt_o
);

   logic [31:0] pc_q, pc_d;
   logic [31:0] id_pc_q, id_pc_d;
   logic [31:0] id_pc4_q, id_pc4_d;
   logic [31:0] id_inst_q, id_inst_d;
   logic        id_valid_q, id_valid_d;
   logic        misalign_q, misalign_d;
   logic [31:0] redirect_cnt_q, redirect_cnt_d;
   logic [31:0] pc_plus4;

   assign pc_plus4 = pc_q + 32'd4;

   // Redirect beats stall; reset is handled in the register block and beats both.
   always_comb begin
      pc_d           = pc_q;
      id_pc_d        = id_pc_q;
      id_pc4_d       = id_pc4_q;
      id_inst_d      = id_inst_q;
      id_valid_d     = id_valid_q;
      misalign_d     = misalign_q;
      redirect_cnt_d = redirect_cnt_q;
      if (npc_op_i) begin
         // Target is forced word-aligned; the bad low bits are only flagged.
         pc_d           = {npc_bj_i[31:2], 2'b00};
         id_inst_d      = NOP_INST;
         id_valid_d     = 1'b0;
         redirect_cnt_d = redirect_cnt_q + 32'd1;
         if (npc_bj_i[1:0] != 2'b00) begin
            misalign_d = 1'b1;
         end
      end else if (!stall_if_i) begin
         pc_d       = pc_plus4;
         id_pc_d    = pc_q;
         id_pc4_d   = pc_plus4;
         id_inst_d  = irom_inst_i;
         id_valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pc_q           <= RESET_PC;
         id_pc_q        <= 32'h0;
         id_pc4_q       <= 32'h0;
         id_inst_q      <= NOP_INST;
         id_valid_q     <= 1'b0;
         misalign_q     <= 1'b0;
         redirect_cnt_q <= 32'h0;
      end else begin
         pc_q           <= pc_d;
         id_pc_q        <= id_pc_d;
         id_pc4_q       <= id_pc4_d;
         id_inst_q      <= id_inst_d;
         id_valid_q     <= id_valid_d;
         misalign_q     <= misalign_d;
         redirect_cnt_q <= redirect_cnt_d;
      end
   end

   assign inst_addr_o    = pc_q;
   assign id_pc_o        = id_pc_q;
   assign id_pc4_o       = id_pc4_q;
   assign id_inst_o      = id_inst_q;
   assign id_valid_o     = id_valid_q;
   assign misalign_err_o = misalign_q;
   assign redirect_cnt_o = redirect_cnt_q;
   assign flush_idex_o   = npc_op_i & ~rst_i;

endmodule

// File: tb/tb_if_stage.sv
// Testbench for if_stage: directed scenarios followed by random stall/redirect/reset traffic.
// The driver predicts every cycle's outputs from a reference model and queues them; the monitor
// compares the DUT against the queue on the falling edge.
module tb_if_stage;

   localparam logic [31:0] NopInst = 32'h0000_0013;

   logic        clk;
   logic        rst;
   logic        stall_if;
   logic        npc_op;
   logic [31:0] npc_bj;
   logic [31:0] irom_inst;
   logic [31:0] inst_addr;
   logic [31:0] id_pc;
   logic [31:0] id_pc4;
   logic [31:0] id_inst;
   logic        id_valid;
   logic        flush_idex;
   logic        misalign_err;
   logic [31:0] redirect_cnt;

   if_stage dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .stall_if_i     (stall_if),
      .npc_op_i       (npc_op),
      .npc_bj_i       (npc_bj),
      .irom_inst_i    (irom_inst),
      .inst_addr_o    (inst_addr),
      .id_pc_o        (id_pc),
      .id_pc4_o       (id_pc4),
      .id_inst_o      (id_inst),
      .id_valid_o     (id_valid),
      .flush_idex_o   (flush_idex),
      .misalign_err_o (misalign_err),
      .redirect_cnt_o (redirect_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synthetic ROM contents: every address gives a distinct word.
   function automatic logic [31:0] rom(input logic [31:0] a);
      return {a[15:0] ^ 16'hA5C3, ~a[31:16]} + 32'h1357_9BDF;
   endfunction

   assign irom_inst = rom(inst_addr);

   typedef struct {
      bit          chk_state;
      logic [31:0] pc;
      logic [31:0] id_pc;
      logic [31:0] id_pc4;
      logic [31:0] id_inst;
      logic        id_valid;
      logic        mis;
      logic [31:0] cnt;
      logic        flush;
   } exp_t;

   exp_t exp_q[$];
   int   tests = 0;
   int   fails = 0;

   // Reference model state (architectural view of the fetch stage).
   bit          m_known = 0;
   logic [31:0] m_pc, m_id_pc, m_id_pc4, m_id_inst, m_cnt;
   logic        m_id_valid, m_mis;

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
      end
   endtask

   // Apply one cycle of inputs: predict this cycle's outputs, then advance the model one edge.
   task automatic cyc(input bit r, input bit st, input bit op, input logic [31:0] bj);
      exp_t e;
      @(posedge clk);
      #2;
      rst      = r;
      stall_if = st;
      npc_op   = op;
      npc_bj   = bj;
      e.chk_state = m_known;
      e.pc        = m_pc;
      e.id_pc     = m_id_pc;
      e.id_pc4    = m_id_pc4;
      e.id_inst   = m_id_inst;
      e.id_valid  = m_id_valid;
      e.mis       = m_mis;
      e.cnt       = m_cnt;
      e.flush     = op && !r;
      exp_q.push_back(e);
      if (r) begin
         m_known = 1;
         m_pc = 0; m_id_pc = 0; m_id_pc4 = 0; m_id_inst = NopInst;
         m_id_valid = 0; m_mis = 0; m_cnt = 0;
      end else if (op) begin
         m_pc       = bj & 32'hFFFF_FFFC;
         m_id_inst  = NopInst;
         m_id_valid = 0;
         m_cnt      = m_cnt + 1;
         if (bj % 4 != 0) m_mis = 1;
      end else if (!st) begin
         m_id_pc    = m_pc;
         m_id_pc4   = m_pc + 4;
         m_id_inst  = rom(m_pc);
         m_id_valid = 1;
         m_pc       = m_pc + 4;
      end
   endtask

   // Monitor: one expected entry per cycle, compared mid-cycle.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check32("flush_idex", {31'b0, flush_idex}, {31'b0, e.flush});
            if (e.chk_state) begin
               check32("inst_addr", inst_addr, e.pc);
               check32("id_pc", id_pc, e.id_pc);
               check32("id_pc4", id_pc4, e.id_pc4);
               check32("id_inst", id_inst, e.id_inst);
               check32("id_valid", {31'b0, id_valid}, {31'b0, e.id_valid});
               check32("misalign_err", {31'b0, misalign_err}, {31'b0, e.mis});
               check32("redirect_cnt", redirect_cnt, e.cnt);
            end
         end
      end
   end

   initial begin
      rst      = 1'b1;
      stall_if = 1'b0;
      npc_op   = 1'b0;
      npc_bj   = 32'h0;

      // Reset held two cycles with a redirect pending: redirect must be ignored.
      cyc(1, 0, 1, 32'h0000_0F00);
      cyc(1, 0, 1, 32'h0000_0F04);
      // Run to PC 0x10, stall three cycles, resume.
      repeat (4) cyc(0, 0, 0, 32'h0);
      repeat (3) cyc(0, 1, 0, 32'h0);
      repeat (4) cyc(0, 0, 0, 32'h0);
      // Redirect at PC 0x20 to 0x100, then let target flow into IF/ID.
      cyc(0, 0, 1, 32'h0000_0100);
      repeat (2) cyc(0, 0, 0, 32'h0);
      // Redirect while stalled.
      cyc(0, 1, 1, 32'h0000_0040);
      repeat (2) cyc(0, 0, 0, 32'h0);
      // Misaligned target; flag must survive a later aligned redirect.
      cyc(0, 0, 1, 32'h0000_0102);
      cyc(0, 0, 0, 32'h0);
      cyc(0, 0, 1, 32'h0000_0200);
      cyc(0, 1, 0, 32'h0);
      // Back-to-back redirects, then PC wrap at the top of the address space.
      cyc(0, 0, 1, 32'h0000_0300);
      cyc(0, 0, 1, 32'hFFFF_FFFC);
      repeat (3) cyc(0, 0, 0, 32'h0);

      // Random traffic with occasional resets.
      for (int i = 0; i < 400; i++) begin
         bit          r, st, op;
         logic [31:0] bj;
         r  = ($urandom_range(0, 49) == 0);
         st = ($urandom_range(0, 3) == 0);
         op = ($urandom_range(0, 5) == 0);
         bj = $urandom();
         if ($urandom_range(0, 3) != 0) bj[1:0] = 2'b00;
         if ($urandom_range(0, 9) == 0) bj = 32'hFFFF_FFF8 | {30'b0, bj[1:0]};
         cyc(r, st, op, bj);
      end
      cyc(0, 0, 0, 32'h0);

      // Drain the scoreboard within a bounded number of cycles.
      for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
      tests++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the pipelined RV32I core. It holds the program counter, drives the instruction ROM address, and registers the fetched instruction into the IF/ID pipeline register. It consumes the branch/jump resolution produced in EX (`npc_op`, `npc_bj`) and redirects fetch to the resolved target. On a redirect it squashes the wrong-path instructions in IF/ID and ID/EX.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value loaded by reset
- `NOP_INST`, 32'h0000_0013, bubble encoding (`addi x0,x0,0`) placed in IF/ID on flush/reset
- `clk` in 1: single clock; all state updates on rising edge
- `rst` in 1: reset, synchronous, active-high
- `stall_if` in 1: from hazard unit; hold PC and IF/ID this cycle
- `npc_op` in 1: from EX branch resolution; 1 = redirect to `npc_bj`
- `npc_bj` in 32: redirect target
- `irom_inst` in 32: instruction from combinational ROM at `inst_addr`
- `inst_addr` out 32: current PC, drives ROM address
- `id_pc` out 32: PC of the instruction in IF/ID
- `id_pc4` out 32: `id_pc + 4`
- `id_inst` out 32: instruction in IF/ID
- `id_valid` out 1: IF/ID holds a real instruction
- `flush_idex` out 1: combinational; equals `npc_op` while not in reset; ID/EX must load a bubble
- `misalign_err` out 1: sticky; a redirect target had `npc_bj[1:0] != 0`
- `redirect_cnt` out 32: count of accepted redirects

## Operation
- State: `pc`, IF/ID (`id_pc`, `id_pc4`, `id_inst`, `id_valid`), `misalign_err`, `redirect_cnt`.
- Per-edge priority, highest first:
  - `rst`: `pc`=RESET_PC, `id_pc`=0, `id_pc4`=0, `id_inst`=NOP_INST, `id_valid`=0, `misalign_err`=0, `redirect_cnt`=0.
  - `npc_op`=1 (overrides `stall_if`): `pc`={npc_bj[31:2],2'b00}; IF/ID loads bubble (`id_inst`=NOP_INST, `id_valid`=0, `id_pc` and `id_pc4` unchanged); `redirect_cnt`+=1 (wraps modulo 2^32); if `npc_bj[1:0]`!=0, set `misalign_err`.
  - `stall_if`=1: all state held.
  - Otherwise: `pc`=pc+4 (32-bit wrap, 0xFFFF_FFFC→0); `id_pc`=pc; `id_pc4`=pc+4; `id_inst`=irom_inst; `id_valid`=1.
- `inst_addr` = `pc` directly.
- `flush_idex` = `npc_op & ~rst`.
- `misalign_err` clears only on `rst`.
- `npc_op` is trusted as given; this block does no branch evaluation.

## Timing
- Reset: effective at the first rising edge with `rst`=1. While `rst`=1, all outputs hold reset values and `flush_idex`=0.
- Reset mid-operation: a pending `npc_op` in the same cycle is discarded and is not counted.
- Sequential fetch: instruction at PC P is in ID exactly one cycle after `inst_addr`=P, when not stalled.
- Redirect latency:
  - `npc_op` sampled at edge n gives `inst_addr`=target during cycle n+1.
  - The target instruction appears in IF/ID after edge n+1.
  - Exactly one IF/ID bubble is inserted; `flush_idex` also kills the ID/EX slot.
- Redirect during stall: the redirect wins. The stall is dropped for that cycle and IF/ID becomes a bubble.
- Back-to-back `npc_op` on consecutive cycles: each one is accepted, the PC follows the latest target, and the counter increments each cycle.
- No handshake. `stall_if` and `npc_op` are level signals sampled every edge.

## Test plan
- Reset: hold `rst` for 2 cycles with `npc_op`=1 → `inst_addr`=0, `id_inst`=0x00000013, `id_valid`=0, `redirect_cnt`=0, `flush_idex`=0. Release → `inst_addr` steps 0,4,8; `id_pc`=0 with `id_valid`=1 after the first post-reset edge.
- Stall: stall for 3 cycles at PC 0x10 → `inst_addr` stays 0x10 and IF/ID contents are unchanged. After release, fetch resumes at 0x14.
- Redirect: at PC 0x20, pulse `npc_op`=1 with `npc_bj`=0x100 →
  - same cycle: `flush_idex`=1
  - next cycle: `inst_addr`=0x100, `id_valid`=0, `redirect_cnt`=1
  - following cycle: `id_pc`=0x100, `id_valid`=1
- Redirect while stalled: `stall_if`=1 and `npc_op`=1 with `npc_bj`=0x40 → `inst_addr`=0x40 next cycle and IF/ID is a bubble.
- Misaligned target: `npc_bj`=0x102 → `inst_addr`=0x100 and `misalign_err`=1, which stays set through later redirects until `rst`.
- Wrap: redirect to 0xFFFF_FFFC, then one unstalled cycle → `inst_addr`=0, `id_pc`=0xFFFF_FFFC, `id_pc4`=0.
